pipe_stage_reg: RTL and testbench

//  Generic ready/valid pipeline stage register for the riscv core, replacing the
//  per-stage always_ff blocks (F/D/E/M/W) with one parametrised block.

---
 rtl/pipe_stage_reg_if.sv | 10 +
 rtl/pipe_stage_reg.sv | 80 ++++++++
 tb/tb_pipe_stage_reg.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: ready/valid payload channel between pipeline stages
interface pipe_stage_reg_if #(
   parameter int WIDTH = 32
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;
   modport master (output valid, output data, input ready);
   modport slave (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: ready/valid pipeline stage with flush, optional 2-entry skid buffer
// and a saturating count of entries discarded by flush
module pipe_stage_reg #(
   parameter int               WIDTH      = 32,
   parameter bit               SKID       = 1'b1,
   parameter logic [WIDTH-1:0] RESET_DATA = '0,
   parameter int               CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   pipe_stage_reg_if.slave       i_in,
   pipe_stage_reg_if.master      o_out,
   input  logic                  i_flush,
   output logic [1:0]            o_occupancy,
   output logic [CNT_W-1:0]      o_kill_cnt
);
   localparam int SW = CNT_W + 1;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t           r_state, w_state_n;
   logic [WIDTH-1:0] r_main, r_skid, w_main_n, w_skid_n;
   logic [CNT_W-1:0] r_kill;
   logic             w_acc, w_emit;
   logic [1:0]       w_killed;
   logic [CNT_W:0]   w_sum;
   // with SKID the ready path sees only registered state, apart from the flush/rst gate
   assign i_in.ready  = !rst && !i_flush && (SKID ? (r_state != TWO) : (r_state == EMPTY || o_out.ready));
   assign o_out.valid = r_state != EMPTY;
   assign o_out.data  = r_main;
   assign o_occupancy = r_state;
   assign o_kill_cnt  = r_kill;
   assign w_acc       = i_in.valid && i_in.ready;
   assign w_emit      = (r_state != EMPTY) && o_out.ready;
   assign w_killed    = r_state - {1'b0, w_emit};
   assign w_sum       = {1'b0, r_kill} + SW'(w_killed);
   always_comb begin
      w_state_n = r_state;
      w_main_n  = r_main;
      w_skid_n  = r_skid;
      if (i_flush) begin
         w_state_n = EMPTY;
         w_main_n  = RESET_DATA;
         w_skid_n  = RESET_DATA;
      end else begin
         case (r_state)
            EMPTY: if (w_acc) begin
               w_state_n = ONE;
               w_main_n  = i_in.data;
            end
            ONE: if (w_acc && w_emit) begin
               w_main_n = i_in.data;
            end else if (w_emit) begin
               w_state_n = EMPTY;
               w_main_n  = RESET_DATA;
            end else if (w_acc && SKID) begin
               w_state_n = TWO;
               w_skid_n  = i_in.data;
            end
            TWO: if (w_emit) begin
               w_state_n = ONE;
               w_main_n  = r_skid;
               w_skid_n  = RESET_DATA;
            end
            default: w_state_n = EMPTY;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
         r_main  <= RESET_DATA;
         r_skid  <= RESET_DATA;
         r_kill  <= '0;
      end else begin
         r_state <= w_state_n;
         r_main  <= w_main_n;
         r_skid  <= w_skid_n;
         if (i_flush) r_kill <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed + random steps on a skid stage and a single-register stage,
// checked against a queue scoreboard and an occupancy/kill model
module tb_pipe_stage_reg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic        iv[2];
   logic [31:0] id[2];
   logic        ordy[2];
   logic        fl[2];
   logic [1:0]  a_occ, b_occ;
   logic [15:0] a_kill;
   logic [1:0]  b_kill;
   int total = 0;
   int bad = 0;
   int m_occ[2];
   int m_kill[2];
   int kmax[2];
   logic m_acc[2];
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.WIDTH(32)) a_in();
   pipe_stage_reg_if #(.WIDTH(32)) a_out();
   pipe_stage_reg_if #(.WIDTH(32)) b_in();
   pipe_stage_reg_if #(.WIDTH(32)) b_out();

   assign a_in.valid  = iv[0];
   assign a_in.data   = id[0];
   assign a_out.ready = ordy[0];
   assign b_in.valid  = iv[1];
   assign b_in.data   = id[1];
   assign b_out.ready = ordy[1];

   pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .RESET_DATA(32'h0), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .i_in(a_in), .o_out(a_out), .i_flush(fl[0]),
      .o_occupancy(a_occ), .o_kill_cnt(a_kill));

   pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .RESET_DATA(32'h0), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .i_in(b_in), .o_out(b_out), .i_flush(fl[1]),
      .o_occupancy(b_occ), .o_kill_cnt(b_kill));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_side(input int k);
      logic [31:0] od, ed;
      logic [15:0] okc;
      logic [1:0]  oo;
      logic        ov, ordy_o, er, ee, ea;
      int          kn;
      if (k == 0) begin
         od = a_out.data; ov = a_out.valid; ordy_o = a_in.ready; oo = a_occ; okc = a_kill;
         ed = (q0.size() > 0) ? q0[0] : 32'h0;
      end else begin
         od = b_out.data; ov = b_out.valid; ordy_o = b_in.ready; oo = b_occ; okc = {14'd0, b_kill};
         ed = (q1.size() > 0) ? q1[0] : 32'h0;
      end
      er = !fl[k] && ((k == 0) ? (m_occ[k] < 2) : (m_occ[k] == 0 || ordy[k]));
      ee = (m_occ[k] > 0) && ordy[k];
      ea = iv[k] && er;
      chk($sformatf("s%0d_in_ready", k), 32'(ordy_o), 32'(er));
      chk($sformatf("s%0d_out_valid", k), 32'(ov), 32'(m_occ[k] > 0));
      chk($sformatf("s%0d_out_data", k), od, ed);
      chk($sformatf("s%0d_occupancy", k), 32'(oo), 32'(m_occ[k]));
      chk($sformatf("s%0d_kill_cnt", k), 32'(okc), 32'(m_kill[k]));
      if (ee) begin
         if (k == 0) void'(q0.pop_front());
         else void'(q1.pop_front());
      end
      if (fl[k]) begin
         kn = m_kill[k] + m_occ[k] - int'(ee);
         m_kill[k] = (kn > kmax[k]) ? kmax[k] : kn;
         m_occ[k] = 0;
         if (k == 0) q0.delete();
         else q1.delete();
      end else begin
         if (ea) begin
            if (k == 0) q0.push_back(id[k]);
            else q1.push_back(id[k]);
         end
         m_occ[k] = m_occ[k] + int'(ea) - int'(ee);
      end
      m_acc[k] = ea;
   endtask

   task automatic step(input int s, input logic v, input logic [31:0] d, input logic r, input logic f);
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; id[k] = 32'h0; ordy[k] = 1'b1; fl[k] = 1'b0;
      end
      iv[s] = v; id[s] = d; ordy[s] = r; fl[s] = f;
      #1;
      for (int k = 0; k < 2; k++) check_side(k);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic        pend;
      logic [31:0] pdat;
      logic        v, r, f;
      kmax[0] = 65535; kmax[1] = 3;
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b1; id[k] = 32'hdead_0000 + 32'(k); ordy[k] = 1'b1; fl[k] = 1'b0;
         m_occ[k] = 0; m_kill[k] = 0; m_acc[k] = 1'b0;
      end
      // T1: reset held three cycles with in_valid asserted
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_a_valid", 32'(a_out.valid), 32'h0);
         chk("rst_a_data", a_out.data, 32'h0);
         chk("rst_a_ready", 32'(a_in.ready), 32'h0);
         chk("rst_b_valid", 32'(b_out.valid), 32'h0);
         chk("rst_b_ready", 32'(b_in.ready), 32'h0);
      end
      rst = 1'b0;
      iv[0] = 1'b0; iv[1] = 1'b0;
      #1;
      chk("post_rst_a_ready", 32'(a_in.ready), 32'h1);
      chk("post_rst_a_occ", 32'(a_occ), 32'h0);
      chk("post_rst_b_ready", 32'(b_in.ready), 32'h1);
      chk("post_rst_a_kill", 32'(a_kill), 32'h0);
      @(negedge clk);
      // T2: streaming
      step(0, 1'b1, 32'h11, 1'b1, 1'b0);
      step(0, 1'b1, 32'h22, 1'b1, 1'b0);
      step(0, 1'b1, 32'h33, 1'b1, 1'b0);
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      // T3: stall fills the skid, held payload waits for space
      step(0, 1'b1, 32'h11, 1'b0, 1'b0);
      step(0, 1'b1, 32'h22, 1'b0, 1'b0);
      step(0, 1'b1, 32'h55, 1'b0, 1'b0);
      step(0, 1'b1, 32'h55, 1'b1, 1'b0);
      step(0, 1'b1, 32'h55, 1'b1, 1'b0);
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      // T4: flush of a full stage with a competing input
      step(0, 1'b1, 32'h66, 1'b0, 1'b0);
      step(0, 1'b1, 32'h77, 1'b0, 1'b0);
      step(0, 1'b1, 32'h44, 1'b0, 1'b1);
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      // T5: flush coinciding with an emit
      step(0, 1'b1, 32'h88, 1'b1, 1'b0);
      step(0, 1'b0, 32'h0, 1'b1, 1'b1);
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      // T6: single-register stage, ready follows out_ready, kill counter saturates
      step(1, 1'b1, 32'h91, 1'b0, 1'b0);
      step(1, 1'b1, 32'h92, 1'b0, 1'b0);
      step(1, 1'b1, 32'h92, 1'b1, 1'b0);
      step(1, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1, 1'b1, 32'ha0 + 32'(i), 1'b0, 1'b0);
         step(1, 1'b0, 32'h0, 1'b0, 1'b1);
      end
      step(1, 1'b0, 32'h0, 1'b1, 1'b0);
      // random traffic on the skid stage, in_valid/in_data held until accepted
      pend = 1'b0;
      pdat = 32'h0;
      for (int i = 0; i < 80; i++) begin
         v = pend ? 1'b1 : 1'($urandom_range(1));
         if (!pend && v) pdat = $urandom;
         r = 1'($urandom_range(1));
         f = ($urandom_range(9) == 0);
         step(0, v, pdat, r, f);
         pend = v && !m_acc[0];
      end
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
